seq_scan_controller: RTL

SEQ_SCAN_CONTROLLER -- requirements
Module: seq_scan_controller

---
 rtl/seq_scan_controller.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/seq_scan_controller.sv
// Sequence-scan controller: steps an attached detector through four patterns,
// counts hits over a fixed bit window per pattern and reports the best pattern.
module seq_scan_controller #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       dwell_len,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             seq_hit,
    output logic [1:0]       lookfor_seq,
    output logic             det_clr,
    output logic             det_bit_en,
    output logic             det_bit,
    output logic             busy,
    output logic             result_valid,
    output logic [1:0]       result_pattern,
    output logic [CNT_W-1:0] result_count,
    output logic             done,
    output logic [1:0]       best_pattern,
    output logic [CNT_W-1:0] best_count
);

    localparam int unsigned BIT_W = 9;
    localparam int unsigned IDX_W = 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(3);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SCAN   = 3'd2,
        REPORT = 3'd3,
        FIN    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BIT_W-1:0]   dwell_q, dwell_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_inc;
    logic [CNT_W-1:0]   hit_cnt_sat;
    logic [CNT_W-1:0]   hit_cnt_scan;

    logic [1:0]         lookfor_seq_d;
    logic               det_clr_d;
    logic               busy_d;
    logic               result_valid_d;
    logic [1:0]         result_pattern_d;
    logic [CNT_W-1:0]   result_count_d;
    logic               done_d;
    logic [1:0]         best_pattern_d;
    logic [CNT_W-1:0]   best_count_d;

    // Detector bit forwarding is a pure gate on the current state.
    assign det_bit_en = bit_valid && (state_q == SCAN);
    assign det_bit    = bit_in;

    // Next-state and next-register logic; abort wins over every transition.
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        dwell_d          = dwell_q;
        bit_cnt_d        = bit_cnt_q;
        hit_cnt_d        = hit_cnt_q;
        result_pattern_d = result_pattern;
        result_count_d   = result_count;
        best_pattern_d   = best_pattern;
        best_count_d     = best_count;

        bit_cnt_inc  = bit_cnt_q + BIT_W'(1);
        hit_cnt_sat  = (hit_cnt_q == {CNT_W{1'b1}}) ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
        hit_cnt_scan = seq_hit ? hit_cnt_sat : hit_cnt_q;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dwell_d        = (dwell_len == 8'd0) ? BIT_W'(256) : BIT_W'(dwell_len);
                        idx_d          = '0;
                        best_pattern_d = '0;
                        best_count_d   = '0;
                        state_d        = CLEAR;
                    end
                end
                CLEAR: begin
                    bit_cnt_d = '0;
                    hit_cnt_d = '0;
                    state_d   = SCAN;
                end
                SCAN: begin
                    hit_cnt_d = hit_cnt_scan;
                    if (bit_valid) begin
                        bit_cnt_d = bit_cnt_inc;
                        // A hit on the final bit is folded into the reported count.
                        if (bit_cnt_inc == dwell_q) begin
                            result_pattern_d = idx_q;
                            result_count_d   = hit_cnt_scan;
                            state_d          = REPORT;
                        end
                    end
                end
                REPORT: begin
                    if (result_count > best_count) begin
                        best_pattern_d = result_pattern;
                        best_count_d   = result_count;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = CLEAR;
                    end
                end
                FIN: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        det_clr_d      = (state_d == CLEAR);
        result_valid_d = (state_d == REPORT);
        done_d         = (state_d == FIN);
        busy_d         = (state_d != IDLE);
        lookfor_seq_d  = ((state_d == CLEAR) || (state_d == SCAN) || (state_d == REPORT))
                         ? idx_d : lookfor_seq;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            dwell_q        <= '0;
            bit_cnt_q      <= '0;
            hit_cnt_q      <= '0;
            lookfor_seq    <= '0;
            det_clr        <= 1'b0;
            busy           <= 1'b0;
            result_valid   <= 1'b0;
            result_pattern <= '0;
            result_count   <= '0;
            done           <= 1'b0;
            best_pattern   <= '0;
            best_count     <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            dwell_q        <= dwell_d;
            bit_cnt_q      <= bit_cnt_d;
            hit_cnt_q      <= hit_cnt_d;
            lookfor_seq    <= lookfor_seq_d;
            det_clr        <= det_clr_d;
            busy           <= busy_d;
            result_valid   <= result_valid_d;
            result_pattern <= result_pattern_d;
            result_count   <= result_count_d;
            done           <= done_d;
            best_pattern   <= best_pattern_d;
            best_count     <= best_count_d;
        end
    end

endmodule
